// File: rtl/std_fu_arbiter.sv
// Round-robin arbiter/sequencer sharing one two-operand functional unit among
// nreq requesters, with latched operands, registered result and a watchdog abort.
module std_fu_arbiter #(
  parameter int width   = 32,
  parameter int nreq    = 4,
  parameter int timeout = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [nreq-1:0]         req_valid,
  input  logic [nreq*width-1:0]   req_left,
  input  logic [nreq*width-1:0]   req_right,
  output logic [nreq-1:0]         req_done,
  output logic [width-1:0]        resp_out,
  output logic                    resp_err,
  output logic                    busy,
  output logic [$clog2(nreq)-1:0] grant,
  output logic                    fu_valid,
  output logic [width-1:0]        fu_left,
  output logic                    fu_left_read_in,
  output logic [width-1:0]        fu_right,
  output logic                    fu_right_read_in,
  input  logic                    fu_ready,
  input  logic [width-1:0]        fu_out,
  input  logic                    fu_out_read_out
);

  localparam int GW = $clog2(nreq);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [width-1:0]  opl_q, opl_d;
  logic [width-1:0]  opr_q, opr_d;
  logic [width-1:0]  result_q, result_d;
  logic              err_q, err_d;

  logic [nreq-1:0]   req_done_q, req_done_d;
  logic [width-1:0]  resp_out_q, resp_out_d;
  logic              resp_err_q, resp_err_d;
  logic              busy_q, busy_d;
  logic              fu_valid_q, fu_valid_d;

  logic              found;
  logic [GW-1:0]     pick;

  // First pending requester at or above ptr, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < nreq; i++) begin
      idx = (int'(ptr_q) + i) % nreq;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    opl_d    = opl_q;
    opr_d    = opr_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          opl_d   = req_left[int'(pick)*width +: width];
          opr_d   = req_right[int'(pick)*width +: width];
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (fu_ready && fu_out_read_out) begin
          result_d = fu_out;
          err_d    = 1'b0;
          state_d  = DONE;
        end else if (cnt_q == 16'(timeout - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        ptr_d   = (grant_q == GW'(nreq - 1)) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered decodes of the next state.
    busy_d     = (state_d != IDLE);
    fu_valid_d = (state_d == ISSUE);
    req_done_d = '0;
    resp_out_d = '0;
    resp_err_d = 1'b0;
    if (state_d == DONE) begin
      req_done_d[grant_d] = 1'b1;
      resp_out_d          = result_d;
      resp_err_d          = err_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      cnt_q      <= '0;
      opl_q      <= '0;
      opr_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      req_done_q <= '0;
      resp_out_q <= '0;
      resp_err_q <= 1'b0;
      busy_q     <= 1'b0;
      fu_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      opl_q      <= opl_d;
      opr_q      <= opr_d;
      result_q   <= result_d;
      err_q      <= err_d;
      req_done_q <= req_done_d;
      resp_out_q <= resp_out_d;
      resp_err_q <= resp_err_d;
      busy_q     <= busy_d;
      fu_valid_q <= fu_valid_d;
    end
  end

  assign req_done         = req_done_q;
  assign resp_out         = resp_out_q;
  assign resp_err         = resp_err_q;
  assign busy             = busy_q;
  assign grant            = grant_q;
  assign fu_valid         = fu_valid_q;
  assign fu_left          = opl_q;
  assign fu_right         = opr_q;
  assign fu_left_read_in  = fu_valid_q;
  assign fu_right_read_in = fu_valid_q;

endmodule

// File: tb/tb_std_fu_arbiter.sv
// Directed bench for std_fu_arbiter: a small adder unit model (combinational,
// never-ready or 2-cycle-delay) sits behind the arbiter; timeout is 4.
module tb_std_fu_arbiter;

  localparam int W  = 32;
  localparam int NR = 4;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*W-1:0]   req_left = '0;
  logic [NR*W-1:0]   req_right = '0;
  logic [NR-1:0]     req_done;
  logic [W-1:0]      resp_out;
  logic              resp_err;
  logic              busy;
  logic [1:0]        grant;
  logic              fu_valid;
  logic [W-1:0]      fu_left;
  logic              fu_left_read_in;
  logic [W-1:0]      fu_right;
  logic              fu_right_read_in;
  logic              fu_ready;
  logic [W-1:0]      fu_out;
  logic              fu_out_read_out;

  int mode = 0;  // 0: combinational, 1: never ready, 2: ready after 2 extra cycles
  int dcnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) dcnt <= fu_valid ? dcnt + 1 : 0;

  assign fu_ready        = fu_valid && ((mode == 0) || (mode == 2 && dcnt == 2));
  assign fu_out_read_out = fu_ready;
  assign fu_out          = fu_left + fu_right;

  std_fu_arbiter #(.width(W), .nreq(NR), .timeout(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_left(req_left), .req_right(req_right),
    .req_done(req_done), .resp_out(resp_out), .resp_err(resp_err),
    .busy(busy), .grant(grant),
    .fu_valid(fu_valid), .fu_left(fu_left), .fu_left_read_in(fu_left_read_in),
    .fu_right(fu_right), .fu_right_read_in(fu_right_read_in),
    .fu_ready(fu_ready), .fu_out(fu_out), .fu_out_read_out(fu_out_read_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_done", 32'(req_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fuv", 32'(fu_valid), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_resp", resp_out, 0);
    chk("rst_fleft", fu_left, 0);
    reset_n = 1'b1;

    // Single request from requester 2, combinational adder
    mode = 0;
    req_left[2*W +: W] = 7;
    req_right[2*W +: W] = 5;
    req_valid = 4'b0100;
    step();
    chk("t1_fuv", 32'(fu_valid), 1);
    chk("t1_lrd", 32'(fu_left_read_in & fu_right_read_in), 1);
    chk("t1_fleft", fu_left, 7);
    chk("t1_fright", fu_right, 5);
    chk("t1_grant", 32'(grant), 2);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_nodone", 32'(req_done), 0);
    step();
    chk("t1_done", 32'(req_done), 32'b0100);
    chk("t1_resp", resp_out, 12);
    chk("t1_err", 32'(resp_err), 0);
    chk("t1_fuv_off", 32'(fu_valid), 0);
    req_valid = 4'b0000;
    step();
    chk("t1_idle_done", 32'(req_done), 0);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_hold_left", fu_left, 7);

    // Fresh reset, then all four held: order 0,1,2,3,0 every 3 cycles
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      req_left[i*W +: W] = 32'(10 * (i + 1));
      req_right[i*W +: W] = 32'(i + 1);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_grant", 32'(grant), 32'(k % NR));
      chk("rr_fuv", 32'(fu_valid), 1);
      step();
      chk("rr_done", 32'(req_done), 32'(1 << (k % NR)));
      chk("rr_resp", resp_out, 32'(11 * ((k % NR) + 1)));
      step();
      chk("rr_gap", 32'(req_done), 0);
    end
    req_valid = 4'b0000;
    step();

    // Timeout with unit never ready (ptr now 1)
    mode = 1;
    req_left[1*W +: W] = 2;
    req_right[1*W +: W] = 3;
    req_valid = 4'b0010;
    for (int c = 0; c < TO; c++) begin
      step();
      chk("to_issue", 32'(fu_valid), 1);
    end
    step();
    chk("to_done", 32'(req_done), 32'b0010);
    chk("to_err", 32'(resp_err), 1);
    chk("to_resp", resp_out, 0);
    mode = 0;
    step();
    chk("to_idle_err", 32'(resp_err), 0);
    step();
    chk("post_to_grant", 32'(grant), 1);
    step();
    chk("post_to_done", 32'(req_done), 32'b0010);
    chk("post_to_resp", resp_out, 5);
    chk("post_to_err", 32'(resp_err), 0);
    req_valid = 4'b0000;
    step();

    // Operand change mid-op with 2-cycle-delay unit (ptr 2, requester 0 wins)
    mode = 2;
    req_left[0 +: W] = 3;
    req_right[0 +: W] = 4;
    req_valid = 4'b0001;
    step();
    chk("lat_grant", 32'(grant), 0);
    chk("lat_left0", fu_left, 3);
    req_left[0 +: W] = 9;
    step();
    chk("lat_left1", fu_left, 3);
    chk("lat_fuv1", 32'(fu_valid), 1);
    step();
    chk("lat_left2", fu_left, 3);
    chk("lat_fuv2", 32'(fu_valid), 1);
    step();
    chk("lat_done", 32'(req_done), 32'b0001);
    chk("lat_resp", resp_out, 7);
    req_valid = 4'b0000;
    step();

    // Reset mid-ISSUE (ptr 1, requester 2 wins)
    mode = 1;
    req_valid = 4'b0100;
    step();
    chk("mr_fuv_pre", 32'(fu_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_fuv", 32'(fu_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_grant", 32'(grant), 0);
    step();
    chk("mr_nodone", 32'(req_done), 0);
    mode = 0;
    req_left[0 +: W] = 1;
    req_right[0 +: W] = 1;
    req_valid = 4'b0101;
    reset_n = 1'b1;
    step();
    chk("mr_grant0", 32'(grant), 0);
    step();
    chk("mr_done0", 32'(req_done), 32'b0001);
    chk("mr_resp0", resp_out, 2);
    step();
    step();
    chk("mr_grant2", 32'(grant), 2);
    step();
    chk("mr_done2", 32'(req_done), 32'b0100);
    req_valid = 4'b0000;
    step();

    // Requester 1 stays high after done while 3 waits (ptr 3)
    req_valid = 4'b0010;
    step();
    chk("fair_g1", 32'(grant), 1);
    req_valid = 4'b1010;
    step();
    chk("fair_d1", 32'(req_done), 32'b0010);
    step();
    step();
    chk("fair_g3", 32'(grant), 3);
    step();
    chk("fair_d3", 32'(req_done), 32'b1000);
    req_valid = 4'b0010;
    step();
    step();
    chk("fair_g1b", 32'(grant), 1);
    step();
    chk("fair_d1b", 32'(req_done), 32'b0010);
    req_valid = 4'b0000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
